// File: rtl/router_pkg.sv
`default_nettype none
// ==========================================================================
// router_pkg : shared state encoding, address codes and port-select helper
// Rev 1.0
// ==========================================================================
package router_pkg;

  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_P0      = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_P1      = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_P2      = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  // Picks the per-port flag for an address; the invalid code selects nothing.
  function automatic logic port_sel(input logic [2:0] flags, input logic [ADDR_W-1:0] a);
    case (a)
      ADDR_P0: return flags[0];
      ADDR_P1: return flags[1];
      ADDR_P2: return flags[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_fsm.sv
`default_nettype none
// ==========================================================================
// router_fsm : packet-sequencing Moore controller for the 1x3 router
// Rev 1.0
// ==========================================================================
module router_fsm #(
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty0,
  input  logic              fifo_empty1,
  input  logic              fifo_empty2,
  input  logic              soft_rst0,
  input  logic              soft_rst1,
  input  logic              soft_rst2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy
);
  import router_pkg::*;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        empties, soft_rsts;
  logic              hdr_ok;

  assign empties   = {fifo_empty2, fifo_empty1, fifo_empty0};
  assign soft_rsts = {soft_rst2, soft_rst1, soft_rst0};
  assign hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid)
        addr_q <= data_in;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS:
        if (hdr_ok)
          next_state = port_sel(empties, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:
        if (port_sel(empties, addr_q)) next_state = LOAD_FIRST_DATA;
      default: next_state = DECODE_ADDRESS;
    endcase
    // Timeout on the port being written aborts the packet from any busy phase.
    if (state != DECODE_ADDRESS && port_sel(soft_rsts, addr_q))
      next_state = DECODE_ADDRESS;
  end

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
  assign busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule
`default_nettype wire

// File: tb/tb_router_fsm.sv
`default_nettype none
// ==========================================================================
// tb_router_fsm : directed + randomized checks of router_fsm against a phase model
// Rev 1.0
// ==========================================================================
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty0, fifo_empty1, fifo_empty2;
  logic       soft_rst0, soft_rst1, soft_rst2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  // Phase letters: D=decode, F=first data, L=load, U=full, A=after full,
  // P=parity, C=check parity, W=wait empty.
  byte ph;
  int  m_addr;

  router_fsm #(.ADDR_W(2)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
    .fifo_empty2(fifo_empty2), .soft_rst0(soft_rst0), .soft_rst1(soft_rst1),
    .soft_rst2(soft_rst2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                 rst_int_reg, write_enb_reg, busy};

  // Output vector {detect,lfd,ld,laf,full,rst_int,write_enb,busy} per phase.
  function automatic logic [7:0] exp_out(input byte p);
    case (p)
      "D": return 8'b1000_0000;
      "F": return 8'b0100_0001;
      "L": return 8'b0010_0010;
      "U": return 8'b0000_1001;
      "A": return 8'b0001_0011;
      "P": return 8'b0000_0011;
      "C": return 8'b0000_0101;
      "W": return 8'b0000_0001;
      default: return 8'bxxxx_xxxx;
    endcase
  endfunction

  task automatic model_step();
    bit empty[3];
    bit srst[3];
    empty = '{fifo_empty0, fifo_empty1, fifo_empty2};
    srst  = '{soft_rst0, soft_rst1, soft_rst2};
    if (!resetn) begin
      ph = "D"; m_addr = 0;
      return;
    end
    if (ph != "D" && m_addr < 3 && srst[m_addr]) begin
      ph = "D";
      return;
    end
    case (ph)
      "D": if (pkt_valid) begin
             m_addr = int'(data_in);
             if (m_addr < 3) ph = empty[m_addr] ? "F" : "W";
           end
      "F": ph = "L";
      "L": if (fifo_full) ph = "U"; else if (!pkt_valid) ph = "P";
      "U": if (!fifo_full) ph = "A";
      "A": ph = parity_done ? "D" : (low_pkt_valid ? "P" : "L");
      "P": ph = "C";
      "C": ph = fifo_full ? "U" : "D";
      "W": if (empty[m_addr]) ph = "F";
      default: ph = "D";
    endcase
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Clock edge, advance the model, then sample outputs 1ns later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic tick_expect(input string tag, input byte p);
    tick();
    check(tag, exp_out(p));
  endtask

  task automatic idle();
    resetn = 1; pkt_valid = 0; data_in = 0; fifo_full = 0;
    fifo_empty0 = 1; fifo_empty1 = 1; fifo_empty2 = 1;
    soft_rst0 = 0; soft_rst1 = 0; soft_rst2 = 0;
    parity_done = 0; low_pkt_valid = 0;
  endtask

  int we_cnt, ri_cnt;

  initial begin
    ph = "D"; m_addr = 0;
    idle();
    resetn = 0;
    tick_expect("reset", "D");
    tick_expect("reset_hold", "D");
    resetn = 1;

    // Port 1 packet with 3 payload bytes
    we_cnt = 0; ri_cnt = 0;
    pkt_valid = 1; data_in = 2'd1;
    tick_expect("p1_lfd", "F");
    data_in = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick_expect("p1_ld", "L");
      we_cnt += int'(write_enb_reg); ri_cnt += int'(rst_int_reg);
    end
    pkt_valid = 0;
    tick_expect("p1_lp", "P");
    we_cnt += int'(write_enb_reg); ri_cnt += int'(rst_int_reg);
    tick_expect("p1_cpe", "C");
    we_cnt += int'(write_enb_reg); ri_cnt += int'(rst_int_reg);
    tick_expect("p1_da", "D");
    we_cnt += int'(write_enb_reg); ri_cnt += int'(rst_int_reg);
    check_int("p1_we_cycles", we_cnt, 4);
    check_int("p1_rst_int_pulses", ri_cnt, 1);

    // Port 2 busy FIFO: wait until empty
    fifo_empty2 = 0; pkt_valid = 1; data_in = 2'd2;
    tick_expect("p2_wte", "W");
    tick_expect("p2_wte_hold", "W");
    tick_expect("p2_wte_hold2", "W");
    fifo_empty2 = 1;
    tick_expect("p2_lfd", "F");
    tick_expect("p2_ld", "L");
    pkt_valid = 0;
    tick_expect("p2_lp", "P");
    tick_expect("p2_cpe", "C");
    tick_expect("p2_da", "D");

    // Port 0 with full stalls; full and parity-drop together favours full
    pkt_valid = 1; data_in = 2'd0;
    tick_expect("p0_lfd", "F");
    tick_expect("p0_ld", "L");
    fifo_full = 1; pkt_valid = 0;
    for (int i = 0; i < 4; i++) tick_expect("p0_full", "U");
    fifo_full = 0; pkt_valid = 1;
    tick_expect("p0_laf", "A");
    tick_expect("p0_laf_to_ld", "L");
    fifo_full = 1;
    tick_expect("p0_full2", "U");
    fifo_full = 0; low_pkt_valid = 1;
    tick_expect("p0_laf2", "A");
    tick_expect("p0_laf_to_lp", "P");
    low_pkt_valid = 0; pkt_valid = 0;
    tick_expect("p0_cpe", "C");
    tick_expect("p0_da", "D");

    // LAF with parity_done and low_pkt_valid: decode wins
    pkt_valid = 1; data_in = 2'd0;
    tick(); tick(); fifo_full = 1; tick(); fifo_full = 0; tick();
    check("laf_reach", exp_out("A"));
    parity_done = 1; low_pkt_valid = 1; pkt_valid = 0;
    tick_expect("laf_both", "D");
    parity_done = 0; low_pkt_valid = 0;

    // Invalid address stays in decode
    pkt_valid = 1; data_in = 2'd3;
    for (int i = 0; i < 3; i++) tick_expect("addr3_da", "D");

    // Soft reset: only the addressed port counts
    data_in = 2'd0;
    tick_expect("sr_lfd", "F");
    tick_expect("sr_ld", "L");
    soft_rst1 = 1;
    tick_expect("sr_other_ignored", "L");
    soft_rst1 = 0; soft_rst0 = 1;
    tick_expect("sr_own_da", "D");
    soft_rst0 = 0; pkt_valid = 0;
    tick_expect("sr_idle", "D");

    // Hard reset while stalled on full
    pkt_valid = 1; data_in = 2'd2;
    tick(); tick(); fifo_full = 1; tick();
    check("rst_full_reach", exp_out("U"));
    resetn = 0;
    tick_expect("rst_in_full", "D");
    idle();
    tick_expect("rst_release", "D");

    // Randomized traffic against the phase model
    for (int i = 0; i < 3000; i++) begin
      resetn        = ($urandom_range(99) >= 2);
      pkt_valid     = ($urandom_range(99) < 70);
      data_in       = 2'($urandom_range(3));
      fifo_full     = ($urandom_range(99) < 25);
      fifo_empty0   = $urandom_range(1);
      fifo_empty1   = $urandom_range(1);
      fifo_empty2   = $urandom_range(1);
      soft_rst0     = ($urandom_range(99) < 4);
      soft_rst1     = ($urandom_range(99) < 4);
      soft_rst2     = ($urandom_range(99) < 4);
      parity_done   = ($urandom_range(99) < 20);
      low_pkt_valid = ($urandom_range(99) < 25);
      tick();
      check("random", exp_out(ph));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish before 500000ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
